// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
//   Shared types and limits for the pipelined add/subtract unit.
//   op_e       : arithmetic mode selected by the 'sub' input.
//   MAX_STAGES : deepest pipeline the unit is built for.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int MAX_STAGES = 8;

endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage
//   One elastic register slice: a valid bit plus a PW-bit payload.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     in_valid_i    : upstream slice (or input port) holds an item
//     in_data_i     : payload offered by upstream
//     out_ready_i   : downstream slice can take this slice's item this cycle
//     valid_o       : this slice holds an item
//     data_o        : payload held by this slice
//   The slice loads whenever it is empty or its own item is leaving, so
//   bubbles collapse and a full chain still moves one item per cycle.
//   The payload only changes on an actual load; an emptying slice keeps
//   its last payload.
module pipe_adder_stage #(
    parameter int PW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [PW-1:0] in_data_i,
    input  logic          out_ready_i,
    output logic          valid_o,
    output logic [PW-1:0] data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [PW-1:0] data_q;
    logic [PW-1:0] data_d;
    logic          advance;

    always_comb begin
        advance = !valid_q || out_ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
//   Pipelined WIDTH-bit add/subtract unit with carry-in, carry-out and
//   signed-overflow flag, behind a STAGES-deep elastic pipeline.
//   Ports:
//     clk, rst_n             : clock, asynchronous active-low reset
//     in_valid / in_ready    : input handshake
//     in1, in0               : operands A and B
//     carry_in               : carry-in (add) / not-borrow (subtract)
//     sub                    : 0 = add, 1 = subtract
//     out_valid / out_ready  : output handshake
//     sum_out, carry_out     : result and carry-out / not-borrow
//     overflow               : two's-complement signed overflow
//     occupancy              : number of items currently in flight
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready may depend combinationally on out_ready; out_valid
//   and the result never depend combinationally on any input. While
//   out_valid && !out_ready the result is held unchanged.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in1,
    input  logic [WIDTH-1:0]            in0,
    input  logic                        carry_in,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            sum_out,
    output logic                        carry_out,
    output logic                        overflow,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    // Payload layout: {overflow, carry, sum}.
    localparam int PW = WIDTH + 2;
    localparam int OW = $clog2(STAGES + 1);

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   raw;
    logic             ovf;
    logic [PW-1:0]    payload;

    logic [STAGES-1:0] v_q;
    logic [PW-1:0]     d_q [STAGES];
    logic [STAGES:0]   rdy;

    logic              accept;
    logic              emit;
    logic [OW-1:0]     occ_q;
    logic [OW-1:0]     occ_d;

    // Subtract is A + ~B + carry_in, so carry_in = 1 means "no borrow in"
    // and the carry-out reads as "no borrow out".
    always_comb begin
        op      = sub ? OP_SUB : OP_ADD;
        b_eff   = (op == OP_SUB) ? ~in0 : in0;
        raw     = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
        ovf     = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != in1[WIDTH-1]);
        payload = {ovf, raw};
    end

    // Ready chain built from registered valid bits only: slice k can load
    // when it is empty or everything downstream of it can move.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = rdy[k+1] | ~v_q[k];
        end
    end

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic          slice_valid;
        logic [PW-1:0] slice_data;

        if (k == 0) begin : g_first
            assign slice_valid = in_valid;
            assign slice_data  = payload;
        end else begin : g_rest
            assign slice_valid = v_q[k-1];
            assign slice_data  = d_q[k-1];
        end

        pipe_adder_stage #(
            .PW(PW)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (slice_valid),
            .in_data_i   (slice_data),
            .out_ready_i (rdy[k+1]),
            .valid_o     (v_q[k]),
            .data_o      (d_q[k])
        );
    end

    // Held low during reset even though the slices read as empty then.
    assign in_ready  = rst_n & rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign {overflow, carry_out, sum_out} = d_q[STAGES-1];

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (accept && !emit) begin
            occ_d = occ_q + OW'(1);
        end else if (emit && !accept) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 1: WIDTH=8, STAGES=2 ----------------
  logic       in_valid, in_ready, carry_in, sub;
  logic [7:0] in1, in0, sum_out;
  logic       out_valid, out_ready, carry_out, overflow;
  logic [1:0] occupancy;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in0       (in0),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .occupancy (occupancy)
  );

  // ---------------- DUT 2: WIDTH=16, STAGES=5 ----------------
  logic        in_valid_w, in_ready_w, carry_in_w, sub_w;
  logic [15:0] in1_w, in0_w, sum_out_w;
  logic        out_valid_w, out_ready_w, carry_out_w, overflow_w;
  logic [2:0]  occupancy_w;

  pipe_adder #(.WIDTH(16), .STAGES(5)) u_dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_w),
    .in_ready  (in_ready_w),
    .in1       (in1_w),
    .in0       (in0_w),
    .carry_in  (carry_in_w),
    .sub       (sub_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready_w),
    .sum_out   (sum_out_w),
    .carry_out (carry_out_w),
    .overflow  (overflow_w),
    .occupancy (occupancy_w)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];  // {overflow, carry, sum zero-extended to 16}

  // Reference: integer arithmetic, signed overflow from an out-of-range
  // signed result.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sb);
    longint ua, ub, sa, sbv, r, sr, half, mask, bin;
    logic c, o;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a);
    ub = longint'(b);
    sa  = (ua >= half) ? ua - 2 * half : ua;
    sbv = (ub >= half) ? ub - 2 * half : ub;
    bin = cin ? 0 : 1;
    if (!sb) begin
      r  = ua + ub + longint'(cin);
      c  = (r > mask);
      sr = sa + sbv + longint'(cin);
    end else begin
      r  = ua - ub - bin;
      c  = (r >= 0);
      sr = sa - sbv - bin;
    end
    o = (sr < -half) || (sr > half - 1);
    return {o, c, 16'(r & mask)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_item8(input int i);
    in1      = 8'(8'h30 + i * 23);
    in0      = 8'(i * 7);
    carry_in = i[0];
    sub      = i[1];
  endtask

  task automatic set_item16(input int i);
    in1_w      = 16'(i * 16'h1F3B + 16'h7FF0);
    in0_w      = 16'((i * 16'h0D11) ^ 16'h8001);
    sub_w      = i[0];
    carry_in_w = i[1];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if ({overflow, carry_out, sum_out} !== 10'd0) begin errors++; $display("FAIL reset_result got %b%b%h want 0", overflow, carry_out, sum_out); end
    checks++; if (in_ready_w !== 1'b0) begin errors++; $display("FAIL reset_in_ready_w got %b want 0", in_ready_w); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    checks++; if (in_ready_w !== 1'b1) begin errors++; $display("FAIL release_in_ready_w got %b want 1", in_ready_w); end
  endtask

  // One item through DUT1 with out_ready high. The acceptance edge counts
  // as edge 1, so with 2 stages the result shows after edge 2.
  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sb,
                         input logic [7:0] e_sum, input logic e_c, input logic e_o, input string name);
    int n;
    bit seen;
    @(posedge clk); #1;
    in1 = a; in0 = b; carry_in = cin; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    seen = 0;
    while (n < 10 && !seen) begin
      if (out_valid === 1'b1) seen = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL %s_latency got %0d want 2", name, n); end
    checks++; if (sum_out !== e_sum) begin errors++; $display("FAIL %s_sum got %h want %h", name, sum_out, e_sum); end
    checks++; if (carry_out !== e_c) begin errors++; $display("FAIL %s_carry got %b want %b", name, carry_out, e_c); end
    checks++; if (overflow !== e_o) begin errors++; $display("FAIL %s_overflow got %b want %b", name, overflow, e_o); end
  endtask

  task automatic test_arith();
    run_vec(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_vec(8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, "sub_05_03");
    run_vec(8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_03_05");
    run_vec(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_vec(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    run_vec(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, "add_cin");
    run_vec(8'h05, 8'h05, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_borrow_in");
  endtask

  // Output drains; result registers keep the last item.
  task automatic test_empty_hold();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_out_valid got %b want 0", out_valid); end
    checks++; if (sum_out !== 8'hFF) begin errors++; $display("FAIL empty_sum_hold got %h want ff", sum_out); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL empty_occupancy got %0d want 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    int idx, emitted, cyc;
    bit acc, emt;
    logic [17:0] exp, got;
    exp_q.delete();
    idx = 0; emitted = 0; cyc = 0;
    @(posedge clk); #1;
    set_item8(0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    while (emitted < 10 && cyc < 60) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      emt = out_valid && out_ready;
      if (cyc == 5) begin
        checks++; if (idx != 2) begin errors++; $display("FAIL b2b_accepted got %0d want 2", idx); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL b2b_full_occupancy got %0d want 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b want 0", in_ready); end
        checks++; if (sum_out !== 8'h30) begin errors++; $display("FAIL b2b_frozen_sum got %h want 30", sum_out); end
      end
      if (cyc >= 6) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap cycle %0d out_valid %b want 1", cyc, out_valid); end
        if (idx < 10) begin
          checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL b2b_steady_occupancy got %0d want 2", occupancy); end
        end
      end
      if (emt) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        got = {overflow, carry_out, 8'h00, sum_out};
        checks++; if (got !== exp) begin errors++; $display("FAIL b2b_item %0d got %h want %h", emitted, got, exp); end
        emitted++;
      end
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(model(8, {8'h00, in1}, {8'h00, in0}, carry_in, sub));
        idx++;
        if (idx < 10) set_item8(idx);
        else in_valid = 1'b0;
      end
      cyc++;
      if (cyc == 6) out_ready = 1'b1;
    end
    checks++; if (emitted != 10) begin errors++; $display("FAIL b2b_emitted got %0d want 10", emitted); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_latency_deep();
    int n;
    @(posedge clk); #1;
    in1_w = 16'h1234; in0_w = 16'h1111; carry_in_w = 1'b0; sub_w = 1'b0;
    in_valid_w = 1'b1; out_ready_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    n = 1;
    while (n < 20 && out_valid_w !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL deep_latency got %0d want 5", n); end
    checks++; if (sum_out_w !== 16'h2345) begin errors++; $display("FAIL deep_sum got %h want 2345", sum_out_w); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream_deep();
    int idx, emitted, cyc, occ_m;
    bit acc, emt;
    logic [31:0] pat;
    logic [17:0] exp, got;
    pat = 32'b1011_0010_1110_0001_0111_1000_1101_0011;
    exp_q.delete();
    idx = 0; emitted = 0; cyc = 0; occ_m = 0;
    @(posedge clk); #1;
    set_item16(0);
    in_valid_w = 1'b1;
    out_ready_w = pat[0];
    while (emitted < 40 && cyc < 600) begin
      @(negedge clk);
      acc = in_valid_w && in_ready_w;
      emt = out_valid_w && out_ready_w;
      checks++; if (occupancy_w !== 3'(occ_m)) begin errors++; $display("FAIL stream_occupancy cycle %0d got %0d want %0d", cyc, occupancy_w, occ_m); end
      if (emt) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        got = {overflow_w, carry_out_w, sum_out_w};
        checks++; if (got !== exp) begin errors++; $display("FAIL stream_item %0d got %h want %h", emitted, got, exp); end
        emitted++;
      end
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(model(16, in1_w, in0_w, carry_in_w, sub_w));
        idx++;
        if (idx < 40) set_item16(idx);
        else in_valid_w = 1'b0;
      end
      occ_m = occ_m + (acc ? 1 : 0) - (emt ? 1 : 0);
      cyc++;
      out_ready_w = pat[cyc % 32];
    end
    checks++; if (emitted != 40) begin errors++; $display("FAIL stream_emitted got %0d want 40", emitted); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_leftover got %0d want 0", exp_q.size()); end
    out_ready_w = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    out_ready_w = 1'b0;
    in_valid_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_item16(i + 50);
      @(posedge clk); #1;
    end
    in_valid_w = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (occupancy_w !== 3'd3) begin errors++; $display("FAIL mid_pre_occupancy got %0d want 3", occupancy_w); end
    checks++; if (out_valid_w !== 1'b1) begin errors++; $display("FAIL mid_pre_out_valid got %b want 1", out_valid_w); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid_w); end
    checks++; if (occupancy_w !== 3'd0) begin errors++; $display("FAIL mid_occupancy got %0d want 0", occupancy_w); end
    checks++; if (in_ready_w !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b want 0", in_ready_w); end
    checks++; if ({overflow_w, carry_out_w, sum_out_w} !== 18'd0) begin errors++; $display("FAIL mid_result got %h want 0", sum_out_w); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready_w = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_w !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b want 1", in_ready_w); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_w !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_ghost_item out_valid seen 1 want 0"); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in1 = '0; in0 = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid_w = 1'b0; in1_w = '0; in0_w = '0; carry_in_w = 1'b0; sub_w = 1'b0; out_ready_w = 1'b1;
    test_reset();
    test_arith();
    test_empty_hold();
    test_back_to_back();
    test_latency_deep();
    test_stream_deep();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
